// File: rtl/rd_capture_manager.sv
// Multi-lane DDR5 read capture: queues read commands, detects the DQS preamble on lane 0,
// captures one word per DQS-high beat across all lanes, strips the CRC beat and drains to DFI.
module rd_capture_manager #(
    parameter int DQ_W       = 8,
    parameter int LANES      = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int GAP_W      = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  en_i,
    input  logic [2:0]            pre_amble_sett_i,
    input  logic [1:0]            bl_i,
    input  logic                  post_amble_sett_i,
    input  logic                  read_crc_enable_i,
    input  logic                  dfi_rddata_en,
    input  logic [LANES-1:0]      dqs_i,
    input  logic [LANES*DQ_W-1:0] dq_i,
    output logic [LANES*DQ_W-1:0] dfi_rddata,
    output logic                  dfi_rddata_valid,
    output logic                  ovf_o,
    output logic                  pre_err_o,
    output logic                  gap_err_o,
    output logic                  lane_err_o,
    output logic                  busy_o,
    output logic [2:0]            saved_pre_amble_o,
    output logic [1:0]            saved_bl_o,
    output logic                  saved_post_amble_o,
    output logic                  saved_read_crc_enable_o
);
    localparam int DW   = LANES * DQ_W;
    localparam int FA_W = $clog2(FIFO_DEPTH);
    localparam int CA_W = $clog2(CMD_DEPTH);
    localparam int FP_W = FA_W + 1;
    localparam int CP_W = CA_W + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_PRE, S_CAPTURE, S_POST} state_t;

    state_t            state_q, state_d;
    logic [6:0]        cmd_mem [CMD_DEPTH];
    logic [CA_W:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic              cmd_empty, cmd_full, cmd_push_req, cmd_push, cmd_pop, cmd_ovf;
    logic [6:0]        cmd_head;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [FA_W:0]     fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic              fifo_empty, fifo_full, fifo_push_req, fifo_push, fifo_pop, fifo_ovf;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        shift_sample, pat_val, pat_mask;
    logic [GAP_W-1:0]  tcnt_q, tcnt_d, tcnt_inc;
    logic [4:0]        beat_q, beat_d, beat_inc, n_data, n_total;
    logic              post_cnt_q, post_cnt_d;
    logic [2:0]        saved_pre_q, saved_pre_d;
    logic [1:0]        saved_bl_q, saved_bl_d;
    logic              saved_post_q, saved_post_d, saved_crc_q, saved_crc_d;
    logic [DW-1:0]     rddata_q, rddata_d;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic              pre_err_q, pre_err_d, gap_err_q, gap_err_d, lane_err_q, lane_err_d;

    // Queue bookkeeping: pointers carry one wrap bit to tell full from empty.
    assign cmd_empty    = (cmd_wr_q == cmd_rd_q);
    assign cmd_full     = (cmd_wr_q[CA_W] != cmd_rd_q[CA_W]) &&
                          (cmd_wr_q[CA_W-1:0] == cmd_rd_q[CA_W-1:0]);
    assign cmd_head     = cmd_mem[cmd_rd_q[CA_W-1:0]];
    assign cmd_push_req = en_i && dfi_rddata_en;
    assign cmd_push     = cmd_push_req && (!cmd_full || cmd_pop);
    assign cmd_ovf      = cmd_push_req && cmd_full && !cmd_pop;
    assign cmd_wr_d     = en_i ? cmd_wr_q + CP_W'(cmd_push) : '0;
    assign cmd_rd_d     = en_i ? cmd_rd_q + CP_W'(cmd_pop) : '0;

    assign fifo_empty   = (fifo_wr_q == fifo_rd_q);
    assign fifo_full    = (fifo_wr_q[FA_W] != fifo_rd_q[FA_W]) &&
                          (fifo_wr_q[FA_W-1:0] == fifo_rd_q[FA_W-1:0]);
    assign fifo_pop     = en_i && !fifo_empty;
    assign fifo_push    = fifo_push_req && (!fifo_full || fifo_pop);
    assign fifo_ovf     = fifo_push_req && fifo_full && !fifo_pop;
    assign fifo_wr_d    = en_i ? fifo_wr_q + FP_W'(fifo_push) : '0;
    assign fifo_rd_d    = en_i ? fifo_rd_q + FP_W'(fifo_pop) : '0;

    assign rddata_d     = !en_i ? '0 : (fifo_pop ? fifo_mem[fifo_rd_q[FA_W-1:0]] : rddata_q);
    assign valid_d      = fifo_pop;
    assign ovf_d        = en_i && (ovf_q || cmd_ovf || fifo_ovf);

    assign shift_sample = {shift_q, dqs_i[0]};
    assign tcnt_inc     = tcnt_q + GAP_W'(1);
    assign beat_inc     = beat_q + 5'd1;

    always_ff @(posedge clk_i) begin
        if (cmd_push)
            cmd_mem[cmd_wr_q[CA_W-1:0]] <= {pre_amble_sett_i, bl_i, post_amble_sett_i, read_crc_enable_i};
        if (fifo_push)
            fifo_mem[fifo_wr_q[FA_W-1:0]] <= dq_i;
    end

    // Preamble pattern is right-aligned: the newest DQS sample is bit 0.
    always_comb begin
        pat_val  = 8'b0000_0010;
        pat_mask = 8'b0000_0011;
        case (saved_pre_q)
            3'b001:  begin pat_val = 8'b0000_0010; pat_mask = 8'b0000_1111; end
            3'b010:  begin pat_val = 8'b0000_1110; pat_mask = 8'b0000_1111; end
            3'b011:  begin pat_val = 8'b0000_0010; pat_mask = 8'b0011_1111; end
            3'b100:  begin pat_val = 8'b0000_1010; pat_mask = 8'b1111_1111; end
            default: ;
        endcase
        case (saved_bl_q)
            2'b01:   n_data = 5'd16;
            2'b10:   n_data = 5'd4;
            default: n_data = 5'd8;
        endcase
        n_total = n_data + 5'(saved_crc_q);
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        tcnt_d        = tcnt_q;
        beat_d        = beat_q;
        post_cnt_d    = post_cnt_q;
        saved_pre_d   = saved_pre_q;
        saved_bl_d    = saved_bl_q;
        saved_post_d  = saved_post_q;
        saved_crc_d   = saved_crc_q;
        pre_err_d     = 1'b0;
        gap_err_d     = 1'b0;
        lane_err_d    = lane_err_q;
        cmd_pop       = 1'b0;
        fifo_push_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty) begin
                    {saved_pre_d, saved_bl_d, saved_post_d, saved_crc_d} = cmd_head;
                    shift_d = '0;
                    tcnt_d  = '0;
                    state_d = S_WAIT_PRE;
                end
            end
            S_WAIT_PRE: begin
                shift_d = shift_sample[6:0];
                if ((shift_sample & pat_mask) == pat_val) begin
                    beat_d  = '0;
                    tcnt_d  = '0;
                    state_d = S_CAPTURE;
                end else if (tcnt_inc == GAP_MAX) begin
                    pre_err_d = 1'b1;
                    cmd_pop   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_CAPTURE: begin
                if (dqs_i[0]) begin
                    beat_d        = beat_inc;
                    tcnt_d        = '0;
                    fifo_push_req = (beat_q < n_data);
                    if (dqs_i != '1)
                        lane_err_d = 1'b1;
                    if (beat_inc == n_total) begin
                        post_cnt_d = 1'b0;
                        state_d    = S_POST;
                    end
                end else if (tcnt_inc == GAP_MAX) begin
                    gap_err_d = 1'b1;
                    cmd_pop   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_POST: begin
                if (post_cnt_q == saved_post_q) begin
                    cmd_pop = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    post_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disable acts as a synchronous flush that overrides everything above.
        if (!en_i) begin
            state_d       = S_IDLE;
            shift_d       = '0;
            tcnt_d        = '0;
            beat_d        = '0;
            post_cnt_d    = 1'b0;
            saved_pre_d   = '0;
            saved_bl_d    = '0;
            saved_post_d  = 1'b0;
            saved_crc_d   = 1'b0;
            pre_err_d     = 1'b0;
            gap_err_d     = 1'b0;
            lane_err_d    = 1'b0;
            cmd_pop       = 1'b0;
            fifo_push_req = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            cmd_wr_q     <= '0;
            cmd_rd_q     <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            shift_q      <= '0;
            tcnt_q       <= '0;
            beat_q       <= '0;
            post_cnt_q   <= 1'b0;
            saved_pre_q  <= '0;
            saved_bl_q   <= '0;
            saved_post_q <= 1'b0;
            saved_crc_q  <= 1'b0;
            rddata_q     <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            pre_err_q    <= 1'b0;
            gap_err_q    <= 1'b0;
            lane_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_rd_q     <= cmd_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            shift_q      <= shift_d;
            tcnt_q       <= tcnt_d;
            beat_q       <= beat_d;
            post_cnt_q   <= post_cnt_d;
            saved_pre_q  <= saved_pre_d;
            saved_bl_q   <= saved_bl_d;
            saved_post_q <= saved_post_d;
            saved_crc_q  <= saved_crc_d;
            rddata_q     <= rddata_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            pre_err_q    <= pre_err_d;
            gap_err_q    <= gap_err_d;
            lane_err_q   <= lane_err_d;
        end
    end

    assign dfi_rddata              = rddata_q;
    assign dfi_rddata_valid        = valid_q;
    assign ovf_o                   = ovf_q;
    assign pre_err_o               = pre_err_q;
    assign gap_err_o               = gap_err_q;
    assign lane_err_o              = lane_err_q;
    assign busy_o                  = (state_q != S_IDLE) || !cmd_empty || !fifo_empty;
    assign saved_pre_amble_o       = saved_pre_q;
    assign saved_bl_o              = saved_bl_q;
    assign saved_post_amble_o      = saved_post_q;
    assign saved_read_crc_enable_o = saved_crc_q;
endmodule

// File: tb/tb_rd_capture_manager.sv
// Self-checking bench for rd_capture_manager: a scoreboard queue holds the words expected on
// the DFI side in order; feature tasks drive bursts and check flags, counts and latency.
module tb_rd_capture_manager;
    localparam int DQ_W  = 8;
    localparam int LANES = 2;
    localparam int DW    = DQ_W * LANES;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n, en, post, crc, rd_en;
    logic [2:0]       pre;
    logic [1:0]       bl;
    logic [LANES-1:0] dqs;
    logic [DW-1:0]    dq;
    logic [DW-1:0]    dfi_rddata;
    logic             dfi_rddata_valid, ovf_o, pre_err_o, gap_err_o, lane_err_o, busy_o;
    logic [2:0]       saved_pre;
    logic [1:0]       saved_bl;
    logic             saved_post, saved_crc;
    logic [28:0]      all_outs;

    int total = 0;
    int bad = 0;
    int rcv_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;

    rd_capture_manager #(
        .DQ_W(DQ_W), .LANES(LANES), .FIFO_DEPTH(16), .CMD_DEPTH(4), .GAP_W(5)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
        .pre_amble_sett_i(pre), .bl_i(bl), .post_amble_sett_i(post),
        .read_crc_enable_i(crc), .dfi_rddata_en(rd_en), .dqs_i(dqs), .dq_i(dq),
        .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid), .ovf_o(ovf_o),
        .pre_err_o(pre_err_o), .gap_err_o(gap_err_o), .lane_err_o(lane_err_o),
        .busy_o(busy_o), .saved_pre_amble_o(saved_pre), .saved_bl_o(saved_bl),
        .saved_post_amble_o(saved_post), .saved_read_crc_enable_o(saved_crc)
    );

    assign all_outs = {dfi_rddata, dfi_rddata_valid, ovf_o, pre_err_o, gap_err_o, lane_err_o,
                       busy_o, saved_pre, saved_bl, saved_post, saved_crc};

    // Scoreboard consumer: every valid beat must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && dfi_rddata_valid) begin
            total++;
            rcv_cnt++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat got=%h required=none", dfi_rddata);
            end else begin
                exp_w = exp_q.pop_front();
                if (dfi_rddata !== exp_w) begin
                    bad++;
                    $display("FAIL rddata got=%h required=%h", dfi_rddata, exp_w);
                end else begin
                    $display("beat ok data=%h", dfi_rddata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pack(input logic [7:0] l0, input logic [7:0] l1);
        return {l1, l0};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] p, input logic [1:0] b, input logic po, input logic c);
        pre = p; bl = b; post = po; crc = c; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drive_pre(input logic [7:0] bits, input int len);
        logic [7:0] v;
        v = bits;
        for (int i = len - 1; i >= 0; i--) begin
            dqs = {LANES{v[i]}};
            dq  = '0;
            @(negedge clk);
        end
        dqs = '0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] w, input logic [LANES-1:0] s, input bit expect_out);
        dqs = s;
        dq  = w;
        if (expect_out) exp_q.push_back(w);
        @(negedge clk);
        dqs = '0;
        dq  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; rd_en = 1'b0; pre = '0; bl = '0; post = 1'b0; crc = 1'b0;
        dqs = '0; dq = '0;
        repeat (3) tick();
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL reset_outs got=%h required=0", all_outs); end
        reset_n = 1'b1;
        tick();
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL post_reset_outs got=%h required=0", all_outs); end
        $display("test_reset done");
    endtask

    task automatic test_bl16();
        rcv_cnt = 0;
        send_cmd(3'b000, 2'b00, 1'b0, 1'b0);
        tick();
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL tc1_busy got=%b required=1", busy_o); end
        drive_pre(8'b0000_0010, 2);
        for (int i = 0; i < 8; i++) begin
            drive_beat(pack(8'hA0 + 8'(i), 8'hB0 + 8'(i)), 2'b11, 1'b1);
            if (i == 0) begin
                total++;
                if (dfi_rddata_valid !== 1'b0) begin
                    bad++; $display("FAIL tc1_latency got=%b required=0", dfi_rddata_valid);
                end
            end
        end
        repeat (6) tick();
        total++;
        if (rcv_cnt != 8) begin bad++; $display("FAIL tc1_count got=%0d required=8", rcv_cnt); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL tc1_pending got=%0d required=0", exp_q.size()); end
        total++;
        if ({ovf_o, lane_err_o, busy_o} !== 3'b000) begin
            bad++; $display("FAIL tc1_flags got=%b required=000", {ovf_o, lane_err_o, busy_o});
        end
        total++;
        if (dfi_rddata !== 16'hB7A7 || dfi_rddata_valid !== 1'b0) begin
            bad++; $display("FAIL tc1_hold got=%h/%b required=b7a7/0", dfi_rddata, dfi_rddata_valid);
        end
        $display("test_bl16 done beats=%0d", rcv_cnt);
    endtask

    task automatic test_bl32_crc();
        rcv_cnt = 0;
        send_cmd(3'b001, 2'b01, 1'b0, 1'b1);
        tick();
        total++;
        if ({saved_pre, saved_bl, saved_post, saved_crc} !== 7'b001_01_0_1) begin
            bad++; $display("FAIL tc2_saved got=%b required=0010101", {saved_pre, saved_bl, saved_post, saved_crc});
        end
        drive_pre(8'b0000_0010, 4);
        for (int i = 0; i < 17; i++)
            drive_beat(pack(8'h10 + 8'(i), 8'h60 + 8'(i)), 2'b11, i < 16);
        repeat (6) tick();
        total++;
        if (rcv_cnt != 16) begin bad++; $display("FAIL tc2_count got=%0d required=16", rcv_cnt); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL tc2_pending got=%0d required=0", exp_q.size()); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL tc2_busy got=%b required=0", busy_o); end
        $display("test_bl32_crc done beats=%0d", rcv_cnt);
    endtask

    task automatic test_back_to_back();
        rcv_cnt = 0;
        send_cmd(3'b100, 2'b10, 1'b0, 1'b0);
        tick();
        send_cmd(3'b100, 2'b10, 1'b1, 1'b0);
        total++;
        if (saved_post !== 1'b0 || saved_bl !== 2'b10) begin
            bad++; $display("FAIL tc3_saved1 got=%b/%b required=0/10", saved_post, saved_bl);
        end
        drive_pre(8'b0000_1010, 8);
        for (int i = 0; i < 4; i++) drive_beat(pack(8'hC0 + 8'(i), 8'hD0 + 8'(i)), 2'b11, 1'b1);
        repeat (3) tick();
        total++;
        if (saved_post !== 1'b1 || saved_pre !== 3'b100) begin
            bad++; $display("FAIL tc3_saved2 got=%b/%b required=1/100", saved_post, saved_pre);
        end
        drive_pre(8'b0000_1010, 8);
        for (int i = 0; i < 4; i++) drive_beat(pack(8'hE0 + 8'(i), 8'hF0 + 8'(i)), 2'b11, 1'b1);
        repeat (6) tick();
        total++;
        if (rcv_cnt != 8) begin bad++; $display("FAIL tc3_count got=%0d required=8", rcv_cnt); end
        total++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL tc3_end got=%0d/%b required=0/0", exp_q.size(), busy_o);
        end
        $display("test_back_to_back done beats=%0d", rcv_cnt);
    endtask

    task automatic test_ovf();
        pre = 3'b000; bl = 2'b00; post = 1'b0; crc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
            total++;
            if (ovf_o !== (i == 4)) begin
                bad++; $display("FAIL tc4_ovf_cmd%0d got=%b required=%b", i, ovf_o, (i == 4));
            end
        end
        rd_en = 1'b0;
        repeat (10) tick();
        total++;
        if (ovf_o !== 1'b1) begin bad++; $display("FAIL tc4_sticky got=%b required=1", ovf_o); end
        en = 1'b0;
        tick();
        total++;
        if (ovf_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL tc4_flush got=%b/%b required=0/0", ovf_o, busy_o);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL tc4_ignored_cmd got=%b required=0", busy_o); end
        en = 1'b1;
        tick();
        $display("test_ovf done");
    endtask

    task automatic test_timeouts();
        int k;
        send_cmd(3'b000, 2'b00, 1'b0, 1'b0);
        tick();
        k = 0;
        while (k < 60 && pre_err_o !== 1'b1) begin tick(); k++; end
        total++;
        if (k != 31) begin bad++; $display("FAIL tc5_pre_err_cycle got=%0d required=31", k); end
        tick();
        total++;
        if (pre_err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL tc5_pre_pulse got=%b/%b required=0/0", pre_err_o, busy_o);
        end
        rcv_cnt = 0;
        send_cmd(3'b000, 2'b00, 1'b0, 1'b0);
        tick();
        drive_pre(8'b0000_0010, 2);
        for (int i = 0; i < 3; i++) drive_beat(pack(8'h30 + 8'(i), 8'h40 + 8'(i)), 2'b11, 1'b1);
        k = 0;
        while (k < 60 && gap_err_o !== 1'b1) begin tick(); k++; end
        total++;
        if (k != 31) begin bad++; $display("FAIL tc5_gap_err_cycle got=%0d required=31", k); end
        tick();
        total++;
        if (gap_err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL tc5_gap_pulse got=%b/%b required=0/0", gap_err_o, busy_o);
        end
        total++;
        if (rcv_cnt != 3 || exp_q.size() != 0) begin
            bad++; $display("FAIL tc5_partial got=%0d/%0d required=3/0", rcv_cnt, exp_q.size());
        end
        $display("test_timeouts done");
    endtask

    task automatic test_lane_err_reset();
        rcv_cnt = 0;
        send_cmd(3'b010, 2'b10, 1'b0, 1'b0);
        tick();
        drive_pre(8'b0000_1110, 4);
        for (int i = 0; i < 4; i++) begin
            drive_beat(pack(8'h50 + 8'(i), 8'h70 + 8'(i)), (i == 1) ? 2'b01 : 2'b11, 1'b1);
            if (i == 0) begin
                total++;
                if (lane_err_o !== 1'b0) begin bad++; $display("FAIL tc6_lane_early got=%b required=0", lane_err_o); end
            end
        end
        repeat (4) tick();
        total++;
        if (lane_err_o !== 1'b1 || rcv_cnt != 4) begin
            bad++; $display("FAIL tc6_lane_err got=%b/%0d required=1/4", lane_err_o, rcv_cnt);
        end
        send_cmd(3'b000, 2'b00, 1'b0, 1'b0);
        tick();
        drive_pre(8'b0000_0010, 2);
        for (int i = 0; i < 2; i++) drive_beat(pack(8'h90 + 8'(i), 8'h91 + 8'(i)), 2'b11, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL tc6_async_reset got=%h required=0", all_outs); end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rcv_cnt = 0;
        send_cmd(3'b000, 2'b10, 1'b0, 1'b0);
        tick();
        drive_pre(8'b0000_0010, 2);
        for (int i = 0; i < 4; i++) drive_beat(pack(8'h20 + 8'(i), 8'h28 + 8'(i)), 2'b11, 1'b1);
        repeat (6) tick();
        total++;
        if (rcv_cnt != 4 || exp_q.size() != 0) begin
            bad++; $display("FAIL tc6_after_reset got=%0d/%0d required=4/0", rcv_cnt, exp_q.size());
        end
        total++;
        if (lane_err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL tc6_end_flags got=%b/%b required=0/0", lane_err_o, busy_o);
        end
        $display("test_lane_err_reset done");
    endtask

    initial begin
        test_reset();
        test_bl16();
        test_bl32_crc();
        test_back_to_back();
        test_ovf();
        test_timeouts();
        test_lane_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
